svf_param_ctrl: RTL
===================

// Module: svf_param_ctrl
// PURPOSE
//  Parameter scheduler for a bank of NUM_VOICES state-variable filter (SVF) voices.
//  Accepts MIDI CC writes (cutoff / resonance, per voice) over a valid/ready port
//    and stores them as per-voice targets.
//  Slews each voice's live CUTOFF_CC / RES_CC by one step per ramp tick, which
//    removes zipper noise in the cutoff_exp_table and resonance sigma-delta path.
//  Voices are serviced one per clock in a round-robin scan.
// PARAMETERS
//  NUM_VOICES   4    number of SVF voices served; 1..16
//  RAMP_DIV     256  clocks per ramp tick; must be >= NUM_VOICES+1
//  CUTOFF_INIT  127  reset value of every cutoff target and current value (7b)
//  RES_INIT     0    reset value of every resonance target and current value (7b)
// PORTS
//  CLK         in   1             system clock
//  RST         in   1             asynchronous reset, active-low
//  CC_VALID    in   1             CC write request
//  CC_READY    out  1             write accepted when CC_VALID&&CC_READY
//  CC_VOICE    in   4             target voice index
//  CC_SEL      in   1             0=cutoff, 1=resonance
//  CC_DATA     in   7             CC value 0..127
//  CUTOFF_OUT  out  7*NUM_VOICES  live cutoff per voice, voice v at [7v+6:7v]
//  RES_OUT     out  7*NUM_VOICES  live resonance per voice, same packing
//  SETTLED     out  1             1 when every live value equals its target
// BEHAVIOUR
//  Reset (RST=0, async)
//   - All targets and live values load CUTOFF_INIT / RES_INIT.
//   - Prescaler=0, state=IDLE, scan_idx=0, SETTLED=1.
//   - CC_READY is 0 while RST is low.
//   - A reset mid-scan abandons the scan; no partial state survives.
//  Prescaler
//   - Counts 0..RAMP_DIV-1 and wraps.
//   - The tick is the cycle the counter equals RAMP_DIV-1.
//  FSM
//   - IDLE: on tick, go to SCAN with scan_idx=0.
//   - SCAN: each clock services voice scan_idx.
//       live_cut steps +1 if tgt>live, -1 if tgt<live, else holds; live_res likewise.
//       If scan_idx==NUM_VOICES-1, go to IDLE and set scan_idx=0; else scan_idx+1.
//   - A ramp step never overshoots: |step| is at most 1, so live never crosses tgt.
//   - The parameter rule guarantees no tick arrives during SCAN.
//  Output timing
//   - CUTOFF_OUT / RES_OUT are registered.
//   - A voice's new value is visible the clock after its scan cycle.
//   - Full 0->127 ramp takes 127 ticks.
//  Handshake
//   - CC_READY = !(state==SCAN && CC_VOICE==scan_idx).
//   - This stalls only a write that collides with the voice being stepped.
//   - An accepted write updates the target at the next edge; the live value is untouched.
//   - A write with CC_VOICE >= NUM_VOICES is accepted (READY=1) and discarded.
//   - Back-to-back writes are allowed every clock; last write wins.
//   - A write and a scan on different voices in the same cycle both take effect.
//  SETTLED
//   - Registered; compares all live values with targets after the edge.
//   - Drops the cycle after any write that makes a target differ from its live value.
// CONFIGURATION
//  SVF_PARAM_CTRL_SNAP_EN
//   - Defined: adds input CC_SNAP (1b), sampled with the write.
//       An accepted write with CC_SNAP=1 loads target AND live value together (no ramp).
//       If that voice is not being scanned, the output changes the next clock.
//   - Undefined: port absent; every write ramps.
// TESTING
//  1. Reset, NUM_VOICES=2, RAMP_DIV=4
//     -> every CUTOFF_OUT lane=127, RES_OUT=0, SETTLED=1, CC_READY=1 after RST released.
//  2. Write v0 cutoff=0
//     -> SETTLED=0 next clock; CUTOFF_OUT[6:0] falls by 1 per tick.
//     -> Reaches 0 after 127 ticks (508 clks +-4); SETTLED returns to 1; v1 stays 127.
//  3. Hold CC_VALID with CC_VOICE=1 during the SCAN cycle of v1
//     -> CC_READY=0 that cycle only, write accepted the next cycle.
//  4. Write CC_VOICE=5 with NUM_VOICES=2
//     -> accepted; all targets and outputs unchanged; SETTLED stays 1.
//  5. Start a ramp to 0 on v0, assert RST low mid-ramp
//     -> outputs return to 127 asynchronously; no further ramping after release.
//  6. With SVF_PARAM_CTRL_SNAP_EN, write v1 res=100 with CC_SNAP=1
//     -> RES_OUT[13:7]=100 the next clock; SETTLED=1.

Source files
------------

// File: rtl/svf_param_ctrl.sv
// svf_param_ctrl: parameter scheduler for a bank of SVF voices.
// CC writes land in per-voice cutoff/resonance targets. Once per ramp tick a
// round-robin scan moves each voice's live value one step toward its target,
// so the cutoff and resonance outputs never jump.
// Optional feature: define SVF_PARAM_CTRL_SNAP_EN to add the cc_snap input.
// A write with cc_snap=1 loads the live value together with the target.
module svf_param_ctrl #(
  parameter int         NUM_VOICES  = 4,
  parameter int         RAMP_DIV    = 256,
  parameter logic [6:0] CUTOFF_INIT = 7'd127,
  parameter logic [6:0] RES_INIT    = 7'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cc_valid,
  output logic                    cc_ready,
  input  logic [3:0]              cc_voice,
  input  logic                    cc_sel,
  input  logic [6:0]              cc_data,
`ifdef SVF_PARAM_CTRL_SNAP_EN
  input  logic                    cc_snap,
`endif
  output logic [7*NUM_VOICES-1:0] cutoff_out,
  output logic [7*NUM_VOICES-1:0] res_out,
  output logic                    settled
);

  localparam int PW = $clog2(RAMP_DIV);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    scan_idx, scan_idx_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          scan_en;
  logic          wr_en;
  logic          snap;
  logic          settled_nxt;

  logic [6:0] tgt_cut  [NUM_VOICES];
  logic [6:0] tgt_res  [NUM_VOICES];
  logic [6:0] live_cut [NUM_VOICES];
  logic [6:0] live_res [NUM_VOICES];
  logic [6:0] tgt_cut_nxt  [NUM_VOICES];
  logic [6:0] tgt_res_nxt  [NUM_VOICES];
  logic [6:0] live_cut_nxt [NUM_VOICES];
  logic [6:0] live_res_nxt [NUM_VOICES];

  // Move a live value one step toward its target; equality holds, so it never overshoots.
  function automatic logic [6:0] ramp_step(input logic [6:0] live, input logic [6:0] tgt);
    if (tgt > live)      return live + 7'd1;
    else if (tgt < live) return live - 7'd1;
    else                 return live;
  endfunction

`ifdef SVF_PARAM_CTRL_SNAP_EN
  assign snap = cc_snap;
`else
  assign snap = 1'b0;
`endif

  assign tick = (presc == PW'(RAMP_DIV - 1));

  // Free-running ramp prescaler; the tick is its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // FSM state and scan pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      scan_idx <= '0;
    end else begin
      state    <= state_nxt;
      scan_idx <= scan_idx_nxt;
    end
  end

  // Next state: a tick starts a scan that visits voices 0..NUM_VOICES-1 once each.
  always_comb begin
    state_nxt    = state;
    scan_idx_nxt = scan_idx;
    case (state)
      IDLE: if (tick) begin
        state_nxt    = SCAN;
        scan_idx_nxt = '0;
      end
      SCAN: if (scan_idx == 4'(NUM_VOICES - 1)) begin
        state_nxt    = IDLE;
        scan_idx_nxt = '0;
      end else begin
        scan_idx_nxt = scan_idx + 4'd1;
      end
      default: begin
        state_nxt    = IDLE;
        scan_idx_nxt = '0;
      end
    endcase
  end

  // FSM outputs: stall only a write aimed at the voice being stepped this cycle.
  always_comb begin
    scan_en  = (state == SCAN);
    cc_ready = rst_n && !(scan_en && (cc_voice == scan_idx));
    wr_en    = cc_valid && cc_ready && ({1'b0, cc_voice} < 5'(NUM_VOICES));
  end

  // Next values of targets and live values: scan step, then any write to another voice.
  always_comb begin
    settled_nxt = 1'b1;
    for (int v = 0; v < NUM_VOICES; v++) begin
      tgt_cut_nxt[v]  = tgt_cut[v];
      tgt_res_nxt[v]  = tgt_res[v];
      live_cut_nxt[v] = live_cut[v];
      live_res_nxt[v] = live_res[v];
      if (scan_en && (scan_idx == 4'(v))) begin
        live_cut_nxt[v] = ramp_step(live_cut[v], tgt_cut[v]);
        live_res_nxt[v] = ramp_step(live_res[v], tgt_res[v]);
      end
      if (wr_en && (cc_voice == 4'(v))) begin
        if (!cc_sel) begin
          tgt_cut_nxt[v] = cc_data;
          if (snap) live_cut_nxt[v] = cc_data;
        end else begin
          tgt_res_nxt[v] = cc_data;
          if (snap) live_res_nxt[v] = cc_data;
        end
      end
      if ((live_cut_nxt[v] != tgt_cut_nxt[v]) || (live_res_nxt[v] != tgt_res_nxt[v]))
        settled_nxt = 1'b0;
    end
  end

  // Per-voice parameter state and the registered settled flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        tgt_cut[v]  <= CUTOFF_INIT;
        tgt_res[v]  <= RES_INIT;
        live_cut[v] <= CUTOFF_INIT;
        live_res[v] <= RES_INIT;
      end
      settled <= 1'b1;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        tgt_cut[v]  <= tgt_cut_nxt[v];
        tgt_res[v]  <= tgt_res_nxt[v];
        live_cut[v] <= live_cut_nxt[v];
        live_res[v] <= live_res_nxt[v];
      end
      settled <= settled_nxt;
    end
  end

  // Pack the live registers onto the output buses, voice v in lane v.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      cutoff_out[7*v +: 7] = live_cut[v];
      res_out[7*v +: 7]    = live_res[v];
    end
  end

endmodule
